// File: rtl/sensor_playa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sensor_playa_pkg
// Description : Shared types and sensor codes for the multi-lane parking
//               detector: lane FSM state encoding and the {a,b} sensor codes.
// Revision    : 1.0 - initial release
// ============================================================================
package sensor_playa_pkg;

    // Lane sequencer states; encodings are fixed so they can be probed directly.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        E1       = 3'd1,
        E2       = 3'd2,
        E3       = 3'd3,
        S1       = 3'd4,
        S2       = 3'd5,
        S3       = 3'd6,
        INVALIDO = 3'd7
    } carril_state_t;

    // Filtered sensor codes, ordered {a, b}.
    localparam logic [1:0] VACIO        = 2'b00;
    localparam logic [1:0] MOVIENDOSE   = 2'b10;
    localparam logic [1:0] ESTACIONADO  = 2'b11;
    localparam logic [1:0] INVALIDO_COD = 2'b01;

    // Sensor code a lane expects while it sits in a given state.
    function automatic logic [1:0] state_code(input carril_state_t s);
        case (s)
            E1, S3:  return MOVIENDOSE;
            E2, S2:  return ESTACIONADO;
            E3, S1:  return INVALIDO_COD;
            default: return VACIO;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/carril_sensor.sv
`default_nettype none
// ============================================================================
// Module      : carril_sensor
// Description : One parking lane. Synchronises and debounces the sensor pair
//               (a, b), then decodes the filtered code with a direction-aware
//               sequencer that pulses inc/dec on a completed entry/exit and
//               holds error while the sequence is invalid.
//               Optional: SENSOR_PLAYA_TIMEOUT_EN adds a per-lane timer that
//               forces INVALIDO when a lane stays mid-sequence TIMEOUT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module carril_sensor
    import sensor_playa_pkg::*;
#(
    parameter int DEBOUNCE = 4,
    parameter int TIMEOUT  = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic a,
    input  logic b,
    output logic inc,
    output logic dec,
    output logic error
);

    // Debounce counter only needs to reach DEBOUNCE-1.
    localparam int         DW       = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);

    logic [1:0]    raw;
    logic [1:0]    filt;
    logic [1:0]    own_code;
    carril_state_t state;
    carril_state_t next_state;
    logic          inc_next;
    logic          dec_next;
    logic          expired;

    assign raw = {a, b};

    for (genvar i = 0; i < 2; i++) begin : g_deb
        logic          sync1;
        logic          sync2;
        logic          filt_q;
        logic [DW-1:0] cnt;

        // Two-flop synchroniser followed by a stability counter; any cycle
        // where the synced bit agrees with the filtered bit restarts the count.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync1  <= 1'b0;
                sync2  <= 1'b0;
                filt_q <= 1'b0;
                cnt    <= '0;
            end else begin
                sync1 <= raw[i];
                sync2 <= sync1;
                if (sync2 == filt_q) begin
                    cnt <= '0;
                end else if (cnt == DEB_LAST) begin
                    filt_q <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign filt[i] = filt_q;
    end

    assign own_code = state_code(state);

`ifdef SENSOR_PLAYA_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] timer;
    logic          mid;

    assign mid     = (state != IDLE) && (state != INVALIDO);
    assign expired = mid && (timer == TMO_LAST);

    // Dwell timer: counts cycles spent in the current mid-sequence state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
        end else if (!mid || (next_state != state)) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end
`else
    // Without the timer a lane never expires; TIMEOUT has no effect.
    assign expired = 1'b0 & (TIMEOUT != 0);
`endif

    // Next-state decode: hold on own code, one-bit moves walk the path,
    // two-bit jumps are invalid, completion back to 00 raises the event.
    always_comb begin
        next_state = state;
        inc_next   = 1'b0;
        dec_next   = 1'b0;
        if (state == INVALIDO) begin
            if (filt == VACIO) begin
                next_state = IDLE;
            end
        end else if (filt == own_code) begin
            if (expired) begin
                next_state = INVALIDO;
            end
        end else if ((filt ^ own_code) == 2'b11) begin
            next_state = INVALIDO;
        end else begin
            case (state)
                IDLE: next_state = (filt == MOVIENDOSE)  ? E1 : S1;
                E1:   next_state = (filt == ESTACIONADO) ? E2 : IDLE;
                E2:   next_state = (filt == MOVIENDOSE)  ? E1 : E3;
                E3: begin
                    if (filt == VACIO) begin
                        next_state = IDLE;
                        inc_next   = 1'b1;
                    end else begin
                        next_state = E2;
                    end
                end
                S1:   next_state = (filt == ESTACIONADO)  ? S2 : IDLE;
                S2:   next_state = (filt == INVALIDO_COD) ? S1 : S3;
                S3: begin
                    if (filt == VACIO) begin
                        next_state = IDLE;
                        dec_next   = 1'b1;
                    end else begin
                        next_state = S2;
                    end
                end
                default: next_state = INVALIDO;
            endcase
        end
    end

    // State register and registered event pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            inc   <= 1'b0;
            dec   <= 1'b0;
        end else begin
            state <= next_state;
            inc   <= inc_next;
            dec   <= dec_next;
        end
    end

    assign error = (state == INVALIDO);

endmodule
`default_nettype wire

// File: rtl/sensor_playa_n.sv
`default_nettype none
// ============================================================================
// Module      : sensor_playa_n
// Description : Multi-lane parking detector. N_CARRILES independent lanes
//               feed a shared saturating occupancy counter with lleno/vacio
//               indicators and a sticky desborde flag for dropped events.
//               Optional: SENSOR_PLAYA_TIMEOUT_EN enables per-lane timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_playa_n
    import sensor_playa_pkg::*;
#(
    parameter  int N_CARRILES = 2,
    parameter  int DEBOUNCE   = 4,
    parameter  int CAPACIDAD  = 15,
    parameter  int TIMEOUT    = 1000,
    localparam int CW         = $clog2(CAPACIDAD + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_CARRILES-1:0] a,
    input  logic [N_CARRILES-1:0] b,
    input  logic                  clr_error,
    output logic [N_CARRILES-1:0] inc,
    output logic [N_CARRILES-1:0] dec,
    output logic [N_CARRILES-1:0] error,
    output logic [CW-1:0]         ocupacion,
    output logic                  lleno,
    output logic                  vacio,
    output logic                  desborde
);

    // Event counts per cycle and a signed sum wide enough for +/-N_CARRILES
    // around any occupancy value.
    localparam int NW = $clog2(N_CARRILES + 1);
    localparam int SW = ((CW > NW) ? CW : NW) + 2;

    logic [NW-1:0]        n_inc;
    logic [NW-1:0]        n_dec;
    logic signed [SW-1:0] sum;
    logic [CW-1:0]        occ_next;
    logic                 sat;

    for (genvar g = 0; g < N_CARRILES; g++) begin : g_carril
        carril_sensor #(
            .DEBOUNCE (DEBOUNCE),
            .TIMEOUT  (TIMEOUT)
        ) u_carril (
            .clk     (clk),
            .reset_n (reset_n),
            .a       (a[g]),
            .b       (b[g]),
            .inc     (inc[g]),
            .dec     (dec[g]),
            .error   (error[g])
        );
    end

    // Net the lane events and clamp the result into [0, CAPACIDAD].
    always_comb begin
        n_inc = '0;
        n_dec = '0;
        for (int i = 0; i < N_CARRILES; i++) begin
            n_inc = n_inc + NW'(inc[i]);
            n_dec = n_dec + NW'(dec[i]);
        end
        sum      = $signed(SW'(ocupacion)) + $signed(SW'(n_inc)) - $signed(SW'(n_dec));
        sat      = 1'b0;
        occ_next = ocupacion;
        if (sum < 0) begin
            occ_next = '0;
            sat      = 1'b1;
        end else if (sum > $signed(SW'(CAPACIDAD))) begin
            occ_next = CW'(CAPACIDAD);
            sat      = 1'b1;
        end else begin
            occ_next = CW'(sum);
        end
    end

    // Occupancy with its indicators registered together; saturation wins
    // over a simultaneous clear of the sticky flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ocupacion <= '0;
            lleno     <= 1'b0;
            vacio     <= 1'b1;
            desborde  <= 1'b0;
        end else begin
            ocupacion <= occ_next;
            lleno     <= (occ_next == CW'(CAPACIDAD));
            vacio     <= (occ_next == '0);
            if (sat) begin
                desborde <= 1'b1;
            end else if (clr_error) begin
                desborde <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sensor_playa_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_sensor_playa_n
// Description : Bench for sensor_playa_n. A behavioural lot model (delay line,
//               run-length filter, path-position tracker, clamped counter)
//               is compared with the DUT every cycle; directed scenarios add
//               literal expectations, then randomized lane traffic follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sensor_playa_n;

    localparam int N   = 2;
    localparam int DEB = 4;
    localparam int CAP = 15;
    localparam int TMO = 50;
    localparam int CW  = $clog2(CAP + 1);

    localparam int D_IDLE = 0;
    localparam int D_IN   = 1;
    localparam int D_OUT  = 2;
    localparam int D_BAD  = 3;

    localparam bit [7:0] ENTRY = 8'b10_11_01_00;
    localparam bit [7:0] EXIT  = 8'b01_11_10_00;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          clr_error = 1'b0;
    logic [N-1:0]  a         = '0;
    logic [N-1:0]  b         = '0;
    logic [N-1:0]  inc;
    logic [N-1:0]  dec;
    logic [N-1:0]  error;
    logic [CW-1:0] ocupacion;
    logic          lleno;
    logic          vacio;
    logic          desborde;

    int n_vec  = 0;
    int n_err  = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sensor_playa_n #(
        .N_CARRILES (N),
        .DEBOUNCE   (DEB),
        .CAPACIDAD  (CAP),
        .TIMEOUT    (TMO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .a         (a),
        .b         (b),
        .clr_error (clr_error),
        .inc       (inc),
        .dec       (dec),
        .error     (error),
        .ocupacion (ocupacion),
        .lleno     (lleno),
        .vacio     (vacio),
        .desborde  (desborde)
    );

    // ---------------- behavioural model ----------------
    bit [1:0] m_d1   [N];
    bit [1:0] m_d2   [N];
    bit [1:0] m_last [N];
    bit [1:0] m_filt [N];
    int       m_run  [N][2];
    int       m_dir  [N];
    int       m_pos  [N];
    bit [1:0] m_code [N];
    int       m_dwell[N];
    bit [N-1:0] m_inc;
    bit [N-1:0] m_dec;
    bit [N-1:0] m_err;
    int       m_occ;
    bit       m_desb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Position of a code along the entry path (00,10,11,01) or exit path (00,01,11,10).
    function automatic int track_pos(input int dir, input bit [1:0] c);
        if (dir == D_IN) begin
            case (c)
                2'b00:   return 0;
                2'b10:   return 1;
                2'b11:   return 2;
                default: return 3;
            endcase
        end
        case (c)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        for (int l = 0; l < N; l++) begin
            m_d1[l] = '0; m_d2[l] = '0; m_last[l] = '0; m_filt[l] = '0;
            m_run[l][0] = 0; m_run[l][1] = 0;
            m_dir[l] = D_IDLE; m_pos[l] = 0; m_code[l] = '0; m_dwell[l] = 0;
        end
        m_inc = '0; m_dec = '0; m_err = '0; m_occ = 0; m_desb = 1'b0;
    endtask

    task automatic lane_step(input int l, input bit [1:0] c);
        bit moved;
        int np;
        moved    = 1'b0;
        m_inc[l] = 1'b0;
        m_dec[l] = 1'b0;
        if (m_dir[l] == D_BAD) begin
            if (c == 2'b00) begin
                m_dir[l] = D_IDLE; m_pos[l] = 0; m_code[l] = 2'b00; moved = 1'b1;
            end
        end else if (c != m_code[l]) begin
            moved = 1'b1;
            if ((c ^ m_code[l]) == 2'b11) begin
                m_dir[l] = D_BAD;
            end else if (m_dir[l] == D_IDLE) begin
                m_dir[l] = (c == 2'b10) ? D_IN : D_OUT;
                m_pos[l] = 1;
            end else begin
                np = track_pos(m_dir[l], c);
                if (np == 0) begin
                    if (m_pos[l] == 3) begin
                        if (m_dir[l] == D_IN) m_inc[l] = 1'b1;
                        else                  m_dec[l] = 1'b1;
                    end
                    m_dir[l] = D_IDLE;
                end
                m_pos[l] = np;
            end
            m_code[l] = c;
        end
`ifdef SENSOR_PLAYA_TIMEOUT_EN
        if (moved || m_dir[l] == D_IDLE || m_dir[l] == D_BAD) begin
            m_dwell[l] = 0;
        end else begin
            m_dwell[l]++;
            if (m_dwell[l] == TMO) begin
                m_dir[l]   = D_BAD;
                m_dwell[l] = 0;
            end
        end
`else
        if (moved) m_dwell[l] = 0;
`endif
        m_err[l] = (m_dir[l] == D_BAD);
    endtask

    task automatic model_step();
        int sum;
        bit v;
        sum = m_occ + $countones(m_inc) - $countones(m_dec);
        if (sum < 0 || sum > CAP) begin
            m_occ  = (sum < 0) ? 0 : CAP;
            m_desb = 1'b1;
        end else begin
            m_occ = sum;
            if (clr_error) m_desb = 1'b0;
        end
        for (int l = 0; l < N; l++) begin
            lane_step(l, m_filt[l]);
            for (int k = 0; k < 2; k++) begin
                v = m_d2[l][k];
                if (v == m_last[l][k]) begin
                    m_run[l][k]++;
                end else begin
                    m_last[l][k] = v;
                    m_run[l][k]  = 1;
                end
                if (v != m_filt[l][k] && m_run[l][k] >= DEB) m_filt[l][k] = v;
            end
            m_d2[l] = m_d1[l];
            m_d1[l] = {a[l], b[l]};
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!reset_n) model_reset();
            else          model_step();
        end
    end

    // Compare every output with the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int l = 0; l < N; l++) begin
                chk($sformatf("inc[%0d]", l),   inc[l],   m_inc[l]);
                chk($sformatf("dec[%0d]", l),   dec[l],   m_dec[l]);
                chk($sformatf("error[%0d]", l), error[l], m_err[l]);
            end
            chk("ocupacion", ocupacion, m_occ);
            chk("lleno",     lleno,     m_occ == CAP);
            chk("vacio",     vacio,     m_occ == 0);
            chk("desborde",  desborde,  m_desb);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_code(input int l, input bit [1:0] c);
        a[l] = c[1];
        b[l] = c[0];
    endtask

    // Walk up to four codes on lanes selected by mask; lane 0 uses p0, lane 1 uses p1.
    task automatic walk(input bit [1:0] mask, input bit [7:0] p0, input bit [7:0] p1, input int hold);
        for (int s = 0; s < 4; s++) begin
            if (mask[0]) set_code(0, p0[7-2*s -: 2]);
            if (mask[1]) set_code(1, p1[7-2*s -: 2]);
            cyc(hold);
        end
    endtask

    initial begin
        #2000000;
        n_err++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        int       first;
        int       pulses;
        int       hold [N];
        int       pidx [N];
        int       plen [N];
        bit [7:0] plan [N];

        reset_n = 1'b0;
        cyc(3);
        chk_en = 1'b1;
        chk("reset ocupacion", ocupacion, 0);
        chk("reset vacio",     vacio,     1);
        chk("reset lleno",     lleno,     0);
        chk("reset error",     error,     0);
        reset_n = 1'b1;
        cyc(3);

        // 1: entry on lane 0, pulse timing from the final 00
        set_code(0, 2'b10); cyc(10);
        set_code(0, 2'b11); cyc(10);
        set_code(0, 2'b01); cyc(10);
        set_code(0, 2'b00);
        first  = -1;
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (inc[0] === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        chk("t1 inc0 latency", first, 2 + DEB + 1);
        chk("t1 inc0 pulses", pulses, 1);
        chk("t1 ocupacion", ocupacion, 1);
        chk("t1 vacio", vacio, 0);

        // 2: exit on lane 1, then an exit from an empty lot saturates
        walk(2'b10, 8'h00, EXIT, 10);
        chk("t2 ocupacion", ocupacion, 0);
        chk("t2 vacio", vacio, 1);
        chk("t2 desborde before", desborde, 0);
        walk(2'b10, 8'h00, EXIT, 10);
        chk("t2 ocupacion sat", ocupacion, 0);
        chk("t2 desborde set", desborde, 1);
        clr_error = 1'b1; cyc(1); clr_error = 1'b0; cyc(2);
        chk("t2 desborde cleared", desborde, 0);

        // 3: two-bit jump on lane 0
        set_code(0, 2'b10); cyc(10);
        set_code(0, 2'b01); cyc(10);
        chk("t3 error set", error[0], 1);
        set_code(0, 2'b11); cyc(10);
        set_code(0, 2'b10); cyc(10);
        chk("t3 error held", error[0], 1);
        set_code(0, 2'b00); cyc(10);
        chk("t3 error cleared", error[0], 0);
        chk("t3 ocupacion", ocupacion, 0);

        // 4: short glitch and a backed-out entry
        a[0] = 1'b1; cyc(2); a[0] = 1'b0; cyc(10);
        chk("t4 glitch error", error[0], 0);
        set_code(0, 2'b10); cyc(10);
        set_code(0, 2'b00); cyc(10);
        chk("t4 ocupacion", ocupacion, 0);

        // 5: fill the lot, then simultaneous entry and exit
        repeat (CAP) walk(2'b01, ENTRY, 8'h00, 8);
        cyc(2);
        chk("t5 ocupacion full", ocupacion, CAP);
        chk("t5 lleno", lleno, 1);
        walk(2'b11, ENTRY, EXIT, 10);
        chk("t5 ocupacion after", ocupacion, CAP);
        chk("t5 lleno after", lleno, 1);
        chk("t5 desborde", desborde, 0);

`ifdef SENSOR_PLAYA_TIMEOUT_EN
        // 6: lane stuck at 11 times out
        set_code(0, 2'b10); cyc(10);
        set_code(0, 2'b11); cyc(60);
        chk("t6 timeout error", error[0], 1);
        set_code(0, 2'b00); cyc(10);
        chk("t6 error cleared", error[0], 0);
`endif

        // Randomized traffic on all lanes
        for (int l = 0; l < N; l++) begin
            hold[l] = 0; pidx[l] = 0; plen[l] = 0; plan[l] = '0;
        end
        for (int t = 0; t < 4000; t++) begin
            for (int l = 0; l < N; l++) begin
                if (hold[l] == 0) begin
                    if (pidx[l] >= plen[l]) begin
                        pidx[l] = 0;
                        case ($urandom_range(0, 3))
                            0: begin plan[l] = ENTRY; plen[l] = 4; end
                            1: begin plan[l] = EXIT;  plen[l] = 4; end
                            2: begin plan[l] = ($urandom_range(0, 1) == 0) ? 8'b10_00_00_00 : 8'b01_00_00_00; plen[l] = 2; end
                            default: begin plan[l] = {2'($urandom_range(0, 3)), 6'b0}; plen[l] = 1; end
                        endcase
                    end
                    set_code(l, plan[l][7-2*pidx[l] -: 2]);
                    pidx[l]++;
                    hold[l] = $urandom_range(1, 12);
                end
                hold[l]--;
            end
            clr_error = ($urandom_range(0, 49) == 0);
            @(negedge clk);
        end
        clr_error = 1'b0;
        cyc(20);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sensor_playa_n.md
Name: sensor_playa_n

Overview:
Multi-lane successor of the two-sensor parking detector. Each of N_CARRILES lanes has a sensor pair (a, b). Each pair is synchronised and debounced, then decoded by a direction-aware FSM that pulses an entry or an exit event and flags invalid sequences. A shared saturating occupancy counter sits at the lot level and drives the lleno/vacio indicators for the barrier and display logic.

Parameters:
N_CARRILES, 2, number of lanes (1..8).
DEBOUNCE, 4, consecutive stable cycles before a filtered input changes (>=1).
CAPACIDAD, 15, maximum occupancy (>=1). Derived localparam CW = $clog2(CAPACIDAD+1).
TIMEOUT, 1000, maximum cycles a lane may stay mid-sequence (used only with the optional feature).

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
a  in  N_CARRILES  outer sensor per lane, asynchronous.
b  in  N_CARRILES  inner sensor per lane, asynchronous.
clr_error  in  1  synchronous pulse; clears the sticky desborde flag.
inc  out  N_CARRILES  1-cycle pulse: entry completed on that lane.
dec  out  N_CARRILES  1-cycle pulse: exit completed on that lane.
error  out  N_CARRILES  level: lane is in INVALIDO.
ocupacion  out  CW  current car count.
lleno  out  1  ocupacion == CAPACIDAD.
vacio  out  1  ocupacion == 0.
desborde  out  1  sticky: an event was dropped by saturation.

Behaviour:
- Reset (async assert, sync release): all FSMs go to IDLE, filters go to 0, and sync flops go to 0. Outputs: inc=0, dec=0, error=0, ocupacion=0, lleno=0, vacio=1, desborde=0.
- Input path per bit: 2-FF synchroniser, then the debounce counter. The filtered value takes the synced value after DEBOUNCE consecutive equal cycles. Any mismatch restarts the count.
- Latency from a stable raw edge to a filtered change: 2 + DEBOUNCE cycles. FSM output follows on the next cycle.
- Lane FSM on filtered {a,b}. States: IDLE(00), E1(10), E2(11), E3(01), S1(01), S2(11), S3(10), INVALIDO.
- Entry path: IDLE->E1->E2->E3. E3 with 00 -> IDLE and inc pulses for 1 cycle.
- Exit path: IDLE->S1->S2->S3. S3 with 00 -> IDLE and dec pulses for 1 cycle.
- Reversals of one step are legal, e.g. E2 with 10 -> E1, or E1 with 00 -> IDLE with no event (car backs out).
- Input equal to the state's own code: hold.
- Both bits changing in one filtered cycle (00<->11 or 10<->01) -> INVALIDO.
- INVALIDO: error=1. Hold until filtered input == 00, then go to IDLE and drop error on that same transition. No event is generated.
- Occupancy: net = popcount(inc) - popcount(dec), computed signed and wide enough for +/-N_CARRILES.
  - next = ocupacion + net, clamped to [0, CAPACIDAD].
  - If clamping occurred, desborde is set the next cycle.
  - Simultaneous entry and exit on different lanes net out with no saturation. Example: full lot, one inc and one dec in the same cycle -> no change, desborde stays 0.
- lleno and vacio are registered alongside ocupacion (same cycle).
- desborde: cleared by clr_error. If a set and clr_error occur in the same cycle, set wins.
- Lanes are fully independent. error on one lane never blocks the other lanes.

Optional Feature:
SENSOR_PLAYA_TIMEOUT_EN.
- Defined: each lane has a counter that runs while the FSM is in E1..E3 or S1..S3 and resets on any state change. When it reaches TIMEOUT, the lane goes to INVALIDO (error=1) and exits as normal on 00.
- Undefined: the counter is absent and a lane may stay mid-sequence indefinitely. TIMEOUT is unused.

Decomposition:
- Package sensor_playa_pkg holds:
  - the state typedef, with encodings IDLE=0, E1..E3=1..3, S1..S3=4..6, INVALIDO=7;
  - the localparam sensor codes VACIO=2'b00, MOVIENDOSE=2'b10, ESTACIONADO=2'b11, INVALIDO_COD=2'b01.
- Sub-module carril_sensor: one lane containing the synchronisers, two debouncers, the FSM and the optional timeout. Ports: inc, dec, error.
- The top instantiates N_CARRILES lanes through a generate loop and adds the occupancy counter.

Test Plan:
1. Reset, then lane 0 entry 00->10->11->01->00, each step held for 10 cycles -> inc[0] is one 1-cycle pulse, 2+DEBOUNCE+1 cycles after the final 00. Result: ocupacion=1, vacio=0.
2. Lane 1 exit 00->01->11->10->00 starting from ocupacion=1 -> dec[1] pulse, ocupacion=0, vacio=1. A second exit -> ocupacion stays 0, desborde=1. Then clr_error -> desborde=0.
3. Lane 0 goes 10->01 in one step (invalid) -> error[0]=1 and stays 1 through 11 and 10. On 00 -> error[0]=0, with no inc and no dec.
4. Glitch of 2 cycles (less than DEBOUNCE=4) on a[0] -> no state change and no outputs. Partial entry 10->00 -> no inc.
5. Preload to CAPACIDAD=15, then inc on lane 0 and dec on lane 1 in the same cycle -> ocupacion=15, lleno=1, desborde=0.
6. With SENSOR_PLAYA_TIMEOUT_EN defined and TIMEOUT=50, hold lane 0 at 11 for 60 cycles -> error[0]=1. Then 00 -> error[0]=0.
